uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one transmitter_system (UART TX byte engine) between NUM_REQ message sources.
//  Each source offers a byte stream (valid/ready, last marks the final byte of a message).
//  Round-robin grant is held for a whole message so messages never interleave on the line.
//  Sits between message generators (e.g. string senders) and the single UART TX instance.
// PARAMETERS
//  NUM_REQ  4    number of requesters, 2..8
//  MAX_GAP  1024 cycles a granted requester may stall mid-message before its grant is revoked; 0 = never
// PORTS
//  clock      in  1          clock
//  reset      in  1          reset, synchronous, active-high
//  req_valid  in  NUM_REQ    requester i has a byte on req_data[8*i+:8]
//  req_data   in  8*NUM_REQ  packed bytes, requester i at [8*i+7:8*i]
//  req_last   in  NUM_REQ    byte offered by requester i is the last of its message
//  req_ready  out NUM_REQ    byte of requester i is taken this cycle (combinational, one-hot or zero)
//  grant      out NUM_REQ    one-hot current owner, 0 when idle (registered)
//  tx_start   out 1          one-cycle start pulse to transmitter_system (registered)
//  tx_data    out 8          byte to transmitter_system, stable from tx_start until tx_done
//  tx_done    in  1          one-cycle pulse from transmitter_system: byte fully shifted out
//  busy       out 1          state != IDLE
//  abort      out 1          one-cycle pulse: grant revoked by MAX_GAP timeout
// BEHAVIOUR
//  Reset: state IDLE; grant, tx_start, tx_data, abort = 0; rr_ptr = 0; gap counter = 0.
//  FSM states: IDLE, LOAD, WAIT.
//  IDLE: if any req_valid, grant the first valid index at or after rr_ptr, wrapping mod NUM_REQ.
//   Grant is registered and the FSM goes to LOAD. No byte is taken in IDLE.
//  LOAD: req_ready[g] = req_valid[g] for the granted g; all other req_ready bits are 0.
//   On handshake (cycle N): tx_data <= req_data[g], last_r <= req_last[g], gap counter cleared.
//   tx_start = 1 in cycle N+1 only; the FSM moves to WAIT.
//   While req_valid[g] = 0 the gap counter increments.
//   When it reaches MAX_GAP-1 (MAX_GAP != 0): abort pulses, grant <= 0, rr_ptr <= g+1 mod NUM_REQ, FSM -> IDLE.
//  WAIT: req_ready = 0. On tx_done: if last_r, grant <= 0, rr_ptr <= g+1 mod NUM_REQ, FSM -> IDLE.
//   Otherwise the FSM returns to LOAD with the grant kept.
//  tx_done outside WAIT is ignored. tx_start asserts at most once per accepted byte.
//  Minimum per-byte overhead: tx_done -> LOAD (1) -> handshake -> tx_start (1).
//   Next tx_start therefore comes 2 cycles after tx_done when the source is ready.
//  The first byte of a message waits 1 extra cycle for the IDLE grant.
//  Requests from non-granted sources are held off (ready=0); they are never dropped.
//  req_valid deasserting while not granted is legal. The source must hold data/last stable while valid && !ready.
//  Single-byte message: last=1 on the first byte; grant is released on its tx_done.
//  rr_ptr wraps NUM_REQ-1 -> 0. Reset mid-message returns everything to reset values at once.
//   No tx_start follows reset; the byte in flight in transmitter_system is not this block's concern.
// TESTING
//  1 req0 sends 0x48,0x69(last); tx_done 10 cycles after each tx_start.
//    -> tx_data 0x48 then 0x69, two tx_start pulses, grant=0001 then 0, busy low after the second tx_done.
//  2 req0 and req1 both valid in the first cycle after reset, 2-byte messages each.
//    -> all of req0's bytes on tx_data before any of req1's; grant 0001 then 0010.
//  3 req0 re-requests right after its message while req1 waits.
//    -> req1 granted next (rr_ptr=1); req0 is served after that.
//  4 MAX_GAP=16; req2 sends one non-last byte, then holds valid low.
//    -> abort pulses 16 cycles after the gap opens; grant=0, busy=0, req3 then granted if valid.
//  5 tx_done pulsed in IDLE and in LOAD.
//    -> no state change, no tx_start, no req_ready change.
//  6 reset asserted in WAIT of a 3-byte message.
//    -> next cycle grant=0, tx_start=0, tx_data=0, busy=0; first new grant goes to req0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte engine between NUM_REQ message sources.
// A grant is held for a whole message. A source that stalls too long mid-message loses the grant.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned MAX_GAP = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   abort
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned GW = (MAX_GAP > 1) ? $clog2(MAX_GAP) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 last_q, last_d;
  logic [7:0]           data_q, data_d;
  logic                 start_q, start_d;
  logic                 abort_q, abort_d;

  logic [PW-1:0]        pick;
  logic                 found;
  logic [PW-1:0]        rr_next;
  logic                 sel_valid;
  logic [7:0]           sel_data;

  // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
  always_comb begin : arb
    int unsigned idx;
    logic [PW-1:0] pidx;
    idx   = 0;
    pidx  = '0;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      pidx = PW'(idx);
      if (!found && req_valid[pidx]) begin
        found = 1'b1;
        pick  = pidx;
      end
    end
  end

  assign rr_next   = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + PW'(1);
  assign sel_valid = req_valid[gidx_q];
  assign sel_data  = req_data[{gidx_q, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_d      = rr_q;
    gap_d     = gap_q;
    last_d    = last_q;
    data_d    = data_q;
    start_d   = 1'b0;
    abort_d   = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          gidx_d        = pick;
          gap_d         = '0;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        if (sel_valid) begin
          req_ready[gidx_q] = 1'b1;
          data_d            = sel_data;
          last_d            = req_last[gidx_q];
          gap_d             = '0;
          start_d           = 1'b1;
          state_d           = WAIT;
        end else if (MAX_GAP != 0) begin
          if (gap_q == GW'(MAX_GAP - 1)) begin
            abort_d = 1'b1;
            grant_d = '0;
            rr_d    = rr_next;
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (last_q) begin
            grant_d = '0;
            rr_d    = rr_next;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      data_q  <= data_d;
      start_q <= start_d;
      abort_q <= abort_d;
    end
  end

  assign grant    = grant_q;
  assign tx_start = start_q;
  assign tx_data  = data_q;
  assign abort    = abort_q;
  assign busy     = (state_q != IDLE);

endmodule
